// File: rtl/dispather_rdma_buffer.sv
// Store-and-forward packet buffer between the dispatcher and the RDMA transmit engine.
// Packets are held until their verdict arrives; only committed packets are forwarded whole.
module dispather_rdma_buffer #(
    parameter int unsigned DATA_AW   = 9,
    parameter int unsigned PKT_AW    = 6,
    parameter int unsigned AF_MARGIN = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_dispather_pkt_wr,
    input  logic [133:0] in_dispather_pkt,
    input  logic         in_dispather_valid_wr,
    input  logic         in_dispather_valid,
    output logic         out_dispather_pkt_almostfull,
    output logic         out_rdma_pkt_wr,
    output logic [133:0] out_rdma_pkt,
    output logic         out_rdma_valid_wr,
    output logic         out_rdma_valid,
    input  logic         in_rdma_pkt_almostfull,
    output logic [31:0]  out_drop_count
);
    localparam int unsigned DW     = 134;
    localparam int unsigned PW     = DATA_AW + 1;
    localparam int unsigned CW     = PKT_AW + 1;
    localparam int unsigned DEPTH  = 1 << DATA_AW;
    localparam int unsigned PDEPTH = 1 << PKT_AW;

    typedef struct packed {
        logic [PW-1:0] start;
        logic [PW-1:0] len;
    } pkt_entry_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [DW-1:0]     mem   [DEPTH];
    pkt_entry_t        pfifo [PDEPTH];

    logic [PW-1:0]     wr_ptr, commit_ptr, rd_ptr, start_ptr, word_cnt, remaining;
    logic              bad;
    logic [PKT_AW-1:0] pf_wr, pf_rd;
    logic [CW-1:0]     pf_cnt;
    state_t            state_q, state_d;

    logic [PW-1:0]     used, free_words, wr_ptr_inc, cnt_next, start_next;
    logic              is_head, wr_ovf, wr_ok, bad_next, pf_full, commit, discard;
    pkt_entry_t        push_entry, pop_entry;
    logic              pop, issue, last_issue;

    // Write-side bookkeeping: overflow detection, packet length and verdict resolution
    always_comb begin
        used       = wr_ptr - rd_ptr;
        free_words = PW'(DEPTH) - used;
        is_head    = in_dispather_pkt_wr && (in_dispather_pkt[133:132] == 2'b01);
        wr_ovf     = in_dispather_pkt_wr && (used == PW'(DEPTH));
        wr_ok      = in_dispather_pkt_wr && !wr_ovf;
        wr_ptr_inc = wr_ptr + PW'(wr_ok);
        cnt_next   = is_head ? PW'(wr_ok) : (word_cnt + PW'(wr_ok));
        bad_next   = (is_head ? 1'b0 : bad) | wr_ovf;
        start_next = is_head ? wr_ptr : start_ptr;
        pf_full    = (pf_cnt == CW'(PDEPTH));
        // An empty or damaged packet can never be forwarded, so it is dropped
        commit     = in_dispather_valid_wr && in_dispather_valid && !bad_next
                     && !pf_full && (cnt_next != '0);
        discard    = in_dispather_valid_wr && !commit;
        push_entry = '{start: start_next, len: cnt_next};
        pop_entry  = pfifo[pf_rd];
    end

    // Output FSM: next state and read-issue decode
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        issue      = 1'b0;
        last_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if ((pf_cnt != '0) && !in_rdma_pkt_almostfull) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                issue      = 1'b1;
                last_issue = (remaining == PW'(1));
                if (last_issue) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data RAM and committed-packet FIFO storage
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[DATA_AW-1:0]] <= in_dispather_pkt;
        end
        if (commit) begin
            pfifo[pf_wr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                      <= IDLE;
            wr_ptr                       <= '0;
            commit_ptr                   <= '0;
            rd_ptr                       <= '0;
            start_ptr                    <= '0;
            word_cnt                     <= '0;
            remaining                    <= '0;
            bad                          <= 1'b0;
            pf_wr                        <= '0;
            pf_rd                        <= '0;
            pf_cnt                       <= '0;
            out_drop_count               <= '0;
            out_dispather_pkt_almostfull <= 1'b0;
            out_rdma_pkt_wr              <= 1'b0;
            out_rdma_pkt                 <= '0;
            out_rdma_valid_wr            <= 1'b0;
            out_rdma_valid               <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_ptr <= start_next;

            if (discard) begin
                wr_ptr         <= commit_ptr;
                word_cnt       <= '0;
                bad            <= 1'b0;
                out_drop_count <= out_drop_count + 32'd1;
            end else if (commit) begin
                wr_ptr     <= wr_ptr_inc;
                commit_ptr <= wr_ptr_inc;
                word_cnt   <= '0;
                bad        <= 1'b0;
                pf_wr      <= pf_wr + PKT_AW'(1);
            end else begin
                wr_ptr   <= wr_ptr_inc;
                word_cnt <= cnt_next;
                bad      <= bad_next;
            end

            pf_cnt <= pf_cnt + CW'(commit) - CW'(pop);

            if (pop) begin
                pf_rd     <= pf_rd + PKT_AW'(1);
                rd_ptr    <= pop_entry.start;
                remaining <= pop_entry.len;
            end else if (issue) begin
                rd_ptr    <= rd_ptr + PW'(1);
                remaining <= remaining - PW'(1);
            end

            out_rdma_pkt_wr   <= issue;
            out_rdma_valid_wr <= last_issue;
            out_rdma_valid    <= last_issue;
            if (issue) begin
                out_rdma_pkt <= mem[rd_ptr[DATA_AW-1:0]];
            end

            out_dispather_pkt_almostfull <= (free_words < PW'(AF_MARGIN))
                                            || (pf_cnt >= CW'(PDEPTH - 4));
        end
    end

endmodule

// File: tb/tb_dispather_rdma_buffer.sv
// Scoreboard bench for dispather_rdma_buffer: committed words are queued when driven
// and compared against RDMA-side output words as they appear.
`timescale 1ns/1ps
module tb_dispather_rdma_buffer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_dispather_pkt_wr = 1'b0;
    logic [133:0] in_dispather_pkt = '0;
    logic         in_dispather_valid_wr = 1'b0;
    logic         in_dispather_valid = 1'b0;
    logic         out_dispather_pkt_almostfull;
    logic         out_rdma_pkt_wr;
    logic [133:0] out_rdma_pkt;
    logic         out_rdma_valid_wr;
    logic         out_rdma_valid;
    logic         in_rdma_pkt_almostfull = 1'b0;
    logic [31:0]  out_drop_count;

    typedef struct packed {
        logic [133:0] w;
        logic         last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   out_words = 0;
    int   head_cyc = 0;
    int   tail_cyc = 0;
    int   tail_in_cyc = 0;
    bit   have_tail = 0;
    bit   gap_check = 0;

    dispather_rdma_buffer dut (
        .clk                          (clk),
        .reset                        (reset),
        .in_dispather_pkt_wr          (in_dispather_pkt_wr),
        .in_dispather_pkt             (in_dispather_pkt),
        .in_dispather_valid_wr        (in_dispather_valid_wr),
        .in_dispather_valid           (in_dispather_valid),
        .out_dispather_pkt_almostfull (out_dispather_pkt_almostfull),
        .out_rdma_pkt_wr              (out_rdma_pkt_wr),
        .out_rdma_pkt                 (out_rdma_pkt),
        .out_rdma_valid_wr            (out_rdma_valid_wr),
        .out_rdma_valid               (out_rdma_valid),
        .in_rdma_pkt_almostfull       (in_rdma_pkt_almostfull),
        .out_drop_count               (out_drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every forwarded word
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (out_rdma_pkt_wr) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h, required no output word", out_rdma_pkt);
            end else begin
                e = sb_q.pop_front();
                if (out_rdma_pkt !== e.w || out_rdma_valid_wr !== e.last || out_rdma_valid !== e.last) begin
                    errors++;
                    $display("FAIL out_word: got %h vwr=%b v=%b, required %h vwr=%b v=%b",
                             out_rdma_pkt, out_rdma_valid_wr, out_rdma_valid, e.w, e.last, e.last);
                end
            end
            out_words++;
            if (out_rdma_pkt[133:132] == 2'b01) begin
                head_cyc = cyc;
                if (gap_check && have_tail) begin
                    checks++;
                    if (cyc - tail_cyc != 2) begin
                        errors++;
                        $display("FAIL packet_gap: got %0d cycles tail-to-head, required 2", cyc - tail_cyc);
                    end
                end
            end
            if (out_rdma_pkt[133:132] == 2'b10) begin
                tail_cyc  = cyc;
                have_tail = 1;
            end
        end else if (out_rdma_valid_wr !== 1'b0 || out_rdma_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_verdict: got vwr=%b v=%b without a word, required 0 0",
                     out_rdma_valid_wr, out_rdma_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        sb_q.delete();
        have_tail = 0;
        out_words = 0;
    endtask

    // vgap=0 puts the verdict on the tail word, otherwise vgap cycles after it
    task automatic send_pkt(input int len, input bit commit, input bit fwd, input int vgap,
                            input logic [3:0] inv);
        logic [133:0] w;
        logic [127:0] d;
        logic [1:0]   typ;
        exp_t         e;
        for (int i = 0; i < len; i++) begin
            d   = {$urandom, $urandom, $urandom, $urandom};
            typ = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
            w   = {typ, (i == len - 1) ? inv : 4'd0, d};
            in_dispather_pkt_wr = 1'b1;
            in_dispather_pkt    = w;
            if (i == len - 1 && vgap == 0) begin
                in_dispather_valid_wr = 1'b1;
                in_dispather_valid    = commit;
            end
            if (fwd) begin
                e.w    = w;
                e.last = (i == len - 1);
                sb_q.push_back(e);
            end
            tick();
            in_dispather_pkt_wr   = 1'b0;
            in_dispather_valid_wr = 1'b0;
            in_dispather_valid    = 1'b0;
        end
        tail_in_cyc = cyc;
        if (vgap > 0) begin
            repeat (vgap - 1) tick();
            in_dispather_valid_wr = 1'b1;
            in_dispather_valid    = commit;
            tick();
            in_dispather_valid_wr = 1'b0;
            in_dispather_valid    = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words outstanding, required 0", sb_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (out_words < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (out_words < target) begin
            errors++;
            $display("FAIL wait_words: got %0d words, required %0d", out_words, target);
        end
    endtask

    task automatic check_val(input string name, input logic [133:0] got, input logic [133:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_val("reset_af", 134'(out_dispather_pkt_almostfull), 134'd0);
        check_val("reset_pkt_wr", 134'(out_rdma_pkt_wr), 134'd0);
        check_val("reset_pkt", out_rdma_pkt, 134'd0);
        check_val("reset_valid_wr", 134'(out_rdma_valid_wr), 134'd0);
        check_val("reset_valid", 134'(out_rdma_valid), 134'd0);
        check_val("reset_drop", 134'(out_drop_count), 134'd0);
    endtask

    task automatic test_basic();
        do_reset();
        send_pkt(4, 1'b1, 1'b1, 0, 4'd3);
        drain(50);
        check_val("basic_words", 134'(out_words), 134'd4);
        check_val("basic_latency_le3", 134'((head_cyc - tail_in_cyc) <= 3 && (head_cyc - tail_in_cyc) >= 1), 134'd1);
        check_val("basic_drop", 134'(out_drop_count), 134'd0);
    endtask

    task automatic test_discard();
        do_reset();
        send_pkt(3, 1'b0, 1'b0, 2, 4'd0);
        send_pkt(2, 1'b1, 1'b1, 0, 4'd5);
        drain(50);
        check_val("discard_words", 134'(out_words), 134'd2);
        check_val("discard_drop", 134'(out_drop_count), 134'd1);
        check_val("discard_wr_ptr", 134'(dut.wr_ptr), 134'd2);
    endtask

    task automatic test_backpressure();
        do_reset();
        in_rdma_pkt_almostfull = 1'b1;
        for (int p = 0; p < 9; p++) send_pkt(40, 1'b1, 1'b1, 0, 4'(p));
        repeat (2) tick();
        check_val("bp_af_at_360", 134'(out_dispather_pkt_almostfull), 134'd0);
        send_pkt(40, 1'b1, 1'b1, 0, 4'd9);
        repeat (2) tick();
        check_val("bp_af_at_400", 134'(out_dispather_pkt_almostfull), 134'd1);
        check_val("bp_held", 134'(out_words), 134'd0);
        gap_check = 1;
        in_rdma_pkt_almostfull = 1'b0;
        drain(2000);
        gap_check = 0;
        check_val("bp_words", 134'(out_words), 134'd400);
        check_val("bp_af_released", 134'(out_dispather_pkt_almostfull), 134'd0);
    endtask

    task automatic test_midpacket_af();
        do_reset();
        send_pkt(8, 1'b1, 1'b1, 0, 4'd1);
        wait_words(3, 50);
        in_rdma_pkt_almostfull = 1'b1;
        send_pkt(8, 1'b1, 1'b1, 0, 4'd2);
        repeat (30) tick();
        check_val("midaf_first_complete", 134'(out_words), 134'd8);
        check_val("midaf_second_held", 134'(sb_q.size()), 134'd8);
        in_rdma_pkt_almostfull = 1'b0;
        drain(100);
        check_val("midaf_words", 134'(out_words), 134'd16);
    endtask

    task automatic test_overflow();
        do_reset();
        in_rdma_pkt_almostfull = 1'b1;
        for (int p = 0; p < 8; p++) send_pkt(62, 1'b1, 1'b1, 0, 4'(p));
        send_pkt(20, 1'b1, 1'b0, 0, 4'd7);
        repeat (2) tick();
        check_val("ovf_drop", 134'(out_drop_count), 134'd1);
        check_val("ovf_af", 134'(out_dispather_pkt_almostfull), 134'd1);
        check_val("ovf_wr_ptr_rollback", 134'(dut.wr_ptr), 134'd496);
        in_rdma_pkt_almostfull = 1'b0;
        drain(2000);
        check_val("ovf_words", 134'(out_words), 134'd496);
        send_pkt(5, 1'b1, 1'b1, 0, 4'd1);
        drain(50);
        check_val("ovf_recover_words", 134'(out_words), 134'd501);
        check_val("ovf_drop_once", 134'(out_drop_count), 134'd1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_pkt(6, 1'b1, 1'b1, 0, 4'd2);
        wait_words(3, 50);
        reset = 1'b1;
        tick();
        check_val("rmid_pkt_wr", 134'(out_rdma_pkt_wr), 134'd0);
        check_val("rmid_pkt", out_rdma_pkt, 134'd0);
        check_val("rmid_valid_wr", 134'(out_rdma_valid_wr), 134'd0);
        check_val("rmid_valid", 134'(out_rdma_valid), 134'd0);
        reset = 1'b0;
        sb_q.delete();
        repeat (20) tick();
        check_val("rmid_no_more_words", 134'(out_words), 134'd3);
        check_val("rmid_af", 134'(out_dispather_pkt_almostfull), 134'd0);
        check_val("rmid_empty", 134'(dut.wr_ptr - dut.rd_ptr), 134'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_discard();
        test_backpressure();
        test_midpacket_af();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1);
    end

endmodule
